// File: rtl/ddr_global_pkg.sv
// Shared DDR clock-tree control types: clock mux select codes and sequencer states.
// Latency: n/a (types only). Backpressure: n/a.
// Holds no logic; imported by the clock mux select controller.
package ddr_global_pkg;

   typedef enum logic [1:0] {
      CLKMUX_OFF  = 2'b00,
      CLKMUX_IN01 = 2'b01,
      CLKMUX_IN10 = 2'b10,
      CLKMUX_IN11 = 2'b11
   } clkmux_sel_t;

   typedef enum logic [1:0] {
      CM_IDLE   = 2'b00,
      CM_PARK   = 2'b01,
      CM_SETTLE = 2'b10
   } clkmux_ctrl_st_t;

   localparam int CLKMUX_SW_CNT_W = 16;

endpackage

// File: rtl/ddr_clkmux_3to1_sel_ctrl.sv
// Glitch-free 3:1 clock mux select sequencer: park at 00, apply new select, settle, then pulse o_done.
// Latency: no-op done in 1 cycle; real switch done PARK_CYC+SETTLE_CYC+1 cycles after accept.
// Backpressure: o_sel_req_rdy only in IDLE; debug switch counter o_sw_cnt under DDR_CLKMUX_CTRL_DBG_EN.
module ddr_clkmux_3to1_sel_ctrl
   import ddr_global_pkg::*;
#(
   parameter int          PARK_CYC   = 4,
   parameter int          SETTLE_CYC = 8,
   parameter int          CNT_W      = 4,
   parameter logic [1:0]  RST_SEL    = 2'b01
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [1:0]  i_sel_req,
   input  logic        i_sel_req_vld,
   output logic        o_sel_req_rdy,
   output logic [1:0]  o_sel,
   output logic [1:0]  o_cur_sel,
   output logic        o_busy,
   output logic        o_done
`ifdef DDR_CLKMUX_CTRL_DBG_EN
   ,
   output logic [CLKMUX_SW_CNT_W-1:0] o_sw_cnt
`endif
);

   localparam logic [CNT_W-1:0] PARK_LD   = CNT_W'(PARK_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

   if (PARK_CYC < 1 || PARK_CYC > (2**CNT_W) - 1) begin : g_park_chk
      $error("PARK_CYC out of range for CNT_W");
   end
   if (SETTLE_CYC < 1 || SETTLE_CYC > (2**CNT_W) - 1) begin : g_settle_chk
      $error("SETTLE_CYC out of range for CNT_W");
   end

   clkmux_ctrl_st_t   st_q, st_n;
   logic [CNT_W-1:0]  cnt_q, cnt_n;
   clkmux_sel_t       req_q, req_n;
   clkmux_sel_t       sel_q, sel_n;
   clkmux_sel_t       cur_q, cur_n;
   logic              busy_q, busy_n;
   logic              done_q, done_n;
   clkmux_sel_t       req_in;

   assign req_in = clkmux_sel_t'(i_sel_req);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         st_q   <= CM_IDLE;
         cnt_q  <= '0;
         req_q  <= clkmux_sel_t'(RST_SEL);
         sel_q  <= clkmux_sel_t'(RST_SEL);
         cur_q  <= clkmux_sel_t'(RST_SEL);
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         st_q   <= st_n;
         cnt_q  <= cnt_n;
         req_q  <= req_n;
         sel_q  <= sel_n;
         cur_q  <= cur_n;
         busy_q <= busy_n;
         done_q <= done_n;
      end
   end

   always_comb begin
      st_n   = st_q;
      cnt_n  = cnt_q;
      req_n  = req_q;
      sel_n  = sel_q;
      cur_n  = cur_q;
      busy_n = busy_q;
      done_n = 1'b0;
      case (st_q)
         CM_IDLE: begin
            if (i_sel_req_vld) begin
               if (req_in == cur_q) begin
                  done_n = 1'b1;
               end else begin
                  // Park first: 00 is the only code safe to pass through between inputs.
                  req_n  = req_in;
                  st_n   = CM_PARK;
                  cnt_n  = PARK_LD;
                  sel_n  = CLKMUX_OFF;
                  busy_n = 1'b1;
               end
            end
         end
         CM_PARK: begin
            if (cnt_q == '0) begin
               sel_n = req_q;
               st_n  = CM_SETTLE;
               cnt_n = SETTLE_LD;
            end else begin
               cnt_n = cnt_q - CNT_W'(1);
            end
         end
         CM_SETTLE: begin
            if (cnt_q == '0) begin
               st_n   = CM_IDLE;
               cur_n  = req_q;
               busy_n = 1'b0;
               done_n = 1'b1;
            end else begin
               cnt_n = cnt_q - CNT_W'(1);
            end
         end
         default: st_n = CM_IDLE;
      endcase
   end

`ifdef DDR_CLKMUX_CTRL_DBG_EN
   logic [CLKMUX_SW_CNT_W-1:0] sw_cnt_q;

   // Only SETTLE completions count; no-op requests never leave IDLE.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sw_cnt_q <= '0;
      end else if (st_q == CM_SETTLE && cnt_q == '0 && sw_cnt_q != '1) begin
         sw_cnt_q <= sw_cnt_q + CLKMUX_SW_CNT_W'(1);
      end
   end

   assign o_sw_cnt = sw_cnt_q;
`else
   // Debug switch counter not built.
`endif

   assign o_sel_req_rdy = (st_q == CM_IDLE);
   assign o_sel         = sel_q;
   assign o_cur_sel     = cur_q;
   assign o_busy        = busy_q;
   assign o_done        = done_q;

endmodule

// File: tb/tb_ddr_clkmux_3to1_sel_ctrl.sv
// Bench for ddr_clkmux_3to1_sel_ctrl: directed scenarios then random requests,
// checked by a timeline model and a done-event scoreboard.
module tb_ddr_clkmux_3to1_sel_ctrl;

   localparam int P   = 4;
   localparam int S   = 8;
   localparam int LAT = P + S + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vld = 1'b0;
   logic [1:0] req = 2'b00;
   logic       rdy, busy, done;
   logic [1:0] sel, cur;
`ifdef DDR_CLKMUX_CTRL_DBG_EN
   logic [15:0] sw;
`endif

   ddr_clkmux_3to1_sel_ctrl dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_sel_req     (req),
      .i_sel_req_vld (vld),
      .o_sel_req_rdy (rdy),
      .o_sel         (sel),
      .o_cur_sel     (cur),
      .o_busy        (busy),
      .o_done        (done)
`ifdef DDR_CLKMUX_CTRL_DBG_EN
      ,
      .o_sw_cnt      (sw)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         done_cyc;
      logic [1:0] cur;
      int         sw;
   } exp_t;
   exp_t q[$];
   exp_t e_pop;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: one switch timeline (accept cycle, old and new select) plus the completion count.
   int         m_acc = -100;
   logic [1:0] m_old = 2'b01;
   logic [1:0] m_new = 2'b01;
   logic [1:0] m_cur = 2'b01;
   int         m_sw  = 0;
   bit         m_rst = 1'b1;

   function automatic bit m_busy(int k);
      return (k > m_acc) && (k < m_acc + LAT);
   endfunction

   function automatic logic [1:0] m_sel(int k);
      if (k <= m_acc)          return m_old;
      else if (k <= m_acc + P) return 2'b00;
      else                     return m_new;
   endfunction

   function automatic logic [1:0] m_cur_at(int k);
      return (k >= m_acc + LAT) ? m_new : m_old;
   endfunction

   task automatic chk(string nm, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (m_rst) begin
         chk("rst_sel",  int'(sel),  1);
         chk("rst_cur",  int'(cur),  1);
         chk("rst_busy", int'(busy), 0);
         chk("rst_done", int'(done), 0);
         chk("rst_rdy",  int'(rdy),  1);
`ifdef DDR_CLKMUX_CTRL_DBG_EN
         chk("rst_sw",   int'(sw),   0);
`endif
      end else begin
         chk("sel",  int'(sel),  int'(m_sel(cyc)));
         chk("cur",  int'(cur),  int'(m_cur_at(cyc)));
         chk("busy", int'(busy), int'(m_busy(cyc)));
         chk("rdy",  int'(rdy),  int'(!m_busy(cyc)));
         if (done) begin
            if (q.size() == 0) begin
               chk("done_expected", int'(q.size() > 0), 1);
            end else begin
               e_pop = q.pop_front();
               chk("done_cyc", cyc, e_pop.done_cyc);
               chk("done_cur", int'(cur), int'(e_pop.cur));
`ifdef DDR_CLKMUX_CTRL_DBG_EN
               chk("done_sw", int'(sw), e_pop.sw);
`endif
            end
         end else if (q.size() > 0 && q[0].done_cyc < cyc) begin
            e_pop = q.pop_front();
            chk("done_seen", int'(done), 1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic accept(int c, logic [1:0] r);
      exp_t e;
      if (r == m_cur) begin
         e.done_cyc = c + 1;
         e.cur      = m_cur;
         e.sw       = m_sw;
      end else begin
         m_old = m_cur;
         m_new = r;
         m_acc = c;
         m_cur = r;
         if (m_sw < 65535) m_sw++;
         e.done_cyc = c + LAT;
         e.cur      = r;
         e.sw       = m_sw;
      end
      q.push_back(e);
   endtask

   // Holds vld until the model says the controller is idle, then lets it drop next cycle.
   task automatic send(logic [1:0] r);
      bit ok;
      ok  = 1'b0;
      vld = 1'b1;
      req = r;
      for (int i = 0; i < 60 && !ok; i++) begin
         if (!m_busy(cyc)) begin
            accept(cyc, r);
            ok = 1'b1;
         end
         tick();
      end
      vld = 1'b0;
      chk("accept_in_time", int'(ok), 1);
   endtask

   task automatic do_reset();
      m_rst = 1'b1;
      rst   = 1'b1;
      q.delete();
      m_acc = -100;
      m_old = 2'b01;
      m_new = 2'b01;
      m_cur = 2'b01;
      m_sw  = 0;
      tick();
      tick();
      rst   = 1'b0;
      m_rst = 1'b0;
   endtask

   initial begin
      logic [1:0] r;
      int         g;
      tick();
      tick();
      tick();
      rst   = 1'b0;
      m_rst = 1'b0;
      tick();

      send(2'b01);
      tick();
      send(2'b10);
      send(2'b11);
      repeat (LAT + 2) tick();
      send(2'b00);
      repeat (LAT + 2) tick();
      send(2'b10);
      repeat (P + 7) tick();
      do_reset();
      tick();
      send(2'b11);
      repeat (LAT + 2) tick();

      for (int n = 0; n < 30; n++) begin
         r = 2'($urandom_range(3, 0));
         g = int'($urandom_range(3, 0));
         send(r);
         repeat (g) tick();
      end
      repeat (LAT + 5) tick();
      chk("queue_drain", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
